// File: rtl/upower_defs.sv
// -----------------------------------------------------------------------------
// upower_defs
// Shared definitions for the uPower multi-cycle control path.
//   - state_e  : sequencer state encodings (also exported on state_o)
//   - OPC_B    : primary opcode of the I-form unconditional branch
//   - PC_W_DEF : default program counter width (word-indexed)
// No ports; imported by upower_pc_next and upower_sequencer.
// -----------------------------------------------------------------------------
package upower_defs;

  localparam int         PC_W_DEF = 32;
  localparam logic [5:0] OPC_B    = 6'd18;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

endpackage

// File: rtl/upower_pc_next.sv
// -----------------------------------------------------------------------------
// upower_pc_next
// Combinational next-PC calculation, shared with the pipelined core.
//   pc         in  PC_W  current instruction address
//   opcode     in  6     primary opcode (OPC_B selects the absolute jump)
//   li         in  24    I-form target, zero-extended
//   bd         in  14    B-form displacement, signed, relative to pc+1
//   branch_req in  1     conditional branch requested
//   alu_zero   in  1     branch condition
//   pc_next    out PC_W  address of the following instruction
// All arithmetic wraps modulo 2^PC_W.
// -----------------------------------------------------------------------------
module upower_pc_next
  import upower_defs::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic [5:0]      opcode,
  input  logic [23:0]     li,
  input  logic [13:0]     bd,
  input  logic            branch_req,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] li_ext;
  logic [PC_W-1:0] bd_ext;

  assign pc_seq = pc + PC_W'(1);
  assign li_ext = PC_W'({8'b0, li});
  // Size cast of a signed operand sign-extends the displacement.
  assign bd_ext = PC_W'($signed(bd));

  // The absolute jump takes priority over a taken conditional branch.
  always_comb begin
    pc_next = pc_seq;
    if (opcode == OPC_B) begin
      pc_next = li_ext;
    end else if (branch_req && alu_zero) begin
      pc_next = pc_seq + bd_ext;
    end
  end

endmodule

// File: rtl/upower_sequencer.sv
// -----------------------------------------------------------------------------
// upower_sequencer
// Multi-cycle control FSM of the uPower core: sequences FETCH, DECODE, EXEC,
// MEM and WB, gates the datapath enables by state and owns the PC.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   run                     leave IDLE / keep sequencing while high
//   opcode, li, bd          decoded instruction fields
//   reg_write_req, mem_read_req, mem_write_req, branch_req
//                           control-unit requests for the current instruction
//   alu_zero                ALU result equals zero
//   mem_ack                 data memory has completed the access
//   pc                      current instruction address
//   ir_load, reg_read_en, alu_en, mem_read_en, mem_write_en, reg_write_en
//                           per-stage datapath enables (Moore, from state)
//   state_o                 current state encoding (upower_defs::state_e)
//   fault                   sticky memory-timeout fault
//   retired                 instructions retired, wraps at 2^32
//   stall_cycles, cycle_count
//                           only with UPOWER_SEQ_PERF_EN defined
//
// Memory handshake: in MEM the strobe is held every cycle until mem_ack is
// sampled high at a rising edge; that edge completes the access. A write
// request suppresses the read strobe.
//
// Build option: define UPOWER_SEQ_PERF_EN to add the MEM-stall and
// non-IDLE cycle counters.
// -----------------------------------------------------------------------------
module upower_sequencer
  import upower_defs::*;
#(
  parameter int              PC_W        = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [5:0]      opcode,
  input  logic [23:0]     li,
  input  logic [13:0]     bd,
  input  logic            reg_write_req,
  input  logic            mem_read_req,
  input  logic            mem_write_req,
  input  logic            branch_req,
  input  logic            alu_zero,
  input  logic            mem_ack,
  output logic [PC_W-1:0] pc,
  output logic            ir_load,
  output logic            reg_read_en,
  output logic            alu_en,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic            reg_write_en,
  output logic [2:0]      state_o,
  output logic            fault,
  output logic [31:0]     retired
`ifdef UPOWER_SEQ_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     cycle_count
`endif
);

  // The wait counter holds the number of no-ack MEM cycles already seen, so
  // the MEM_TIMEOUT-th such cycle is the one where it equals MEM_TIMEOUT-1.
  // An ack in that same cycle still completes the access.
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [31:0] WAIT_LAST  = 32'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_next;
  logic [31:0]     retired_q, retired_d;
  logic [31:0]     wait_q, wait_d;
  logic            fault_q, fault_d;
  logic            retire;

  upower_pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc         (pc_q),
    .opcode     (opcode),
    .li         (li),
    .bd         (bd),
    .branch_req (branch_req),
    .alu_zero   (alu_zero),
    .pc_next    (pc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      wait_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retired_d    = retired_q;
    wait_d       = wait_q;
    fault_d      = fault_q;
    retire       = 1'b0;
    ir_load      = 1'b0;
    reg_read_en  = 1'b0;
    alu_en       = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    reg_write_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_load = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        reg_read_en = 1'b1;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        if (mem_read_req || mem_write_req) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else if (reg_write_req) begin
          state_d = ST_WB;
        end else begin
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        mem_write_en = mem_write_req;
        mem_read_en  = mem_read_req && !mem_write_req;
        wait_d       = wait_q + 32'd1;
        if (mem_ack) begin
          if (reg_write_req) state_d = ST_WB;
          else               retire  = 1'b1;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end
      ST_WB: begin
        reg_write_en = 1'b1;
        retire       = 1'b1;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Retirement is a transition: commit the PC and count the instruction.
    if (retire) begin
      pc_d      = pc_next;
      retired_d = retired_q + 32'd1;
      state_d   = run ? ST_FETCH : ST_IDLE;
    end
  end

  assign pc      = pc_q;
  assign state_o = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

`ifdef UPOWER_SEQ_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] cycle_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      cycle_q <= '0;
    end else begin
      if ((state_q == ST_MEM) && !mem_ack) stall_q <= stall_q + 32'd1;
      if (state_q != ST_IDLE)              cycle_q <= cycle_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign cycle_count  = cycle_q;
`endif

endmodule

// File: tb/tb_upower_sequencer.sv
// -----------------------------------------------------------------------------
// tb_upower_sequencer
// Directed bench for upower_sequencer (PC_W=32, RESET_PC=0, MEM_TIMEOUT=15).
// The driver sets inputs #1 after a rising edge, waits for the next edge and
// queues the hand-computed outputs expected after it; the monitor pops and
// compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_upower_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;

  // Enable vector order: {ir_load, reg_read_en, alu_en, mem_read_en, mem_write_en, reg_write_en}
  localparam logic [5:0] EN_0  = 6'b000000, EN_F  = 6'b100000, EN_D = 6'b010000,
                         EN_E  = 6'b001000, EN_MR = 6'b000100, EN_MW = 6'b000010,
                         EN_W  = 6'b000001;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        run, reg_write_req, mem_read_req, mem_write_req, branch_req, alu_zero, mem_ack;
  logic [5:0]  opcode;
  logic [23:0] li;
  logic [13:0] bd;
  logic [31:0] pc, retired;
  logic        ir_load, reg_read_en, alu_en, mem_read_en, mem_write_en, reg_write_en, fault;
  logic [2:0]  state_o;
`ifdef UPOWER_SEQ_PERF_EN
  logic [31:0] stall_cycles, cycle_count;
`endif

  upower_sequencer #(.PC_W(32), .RESET_PC(32'd0), .MEM_TIMEOUT(15)) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .opcode        (opcode),
    .li            (li),
    .bd            (bd),
    .reg_write_req (reg_write_req),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .branch_req    (branch_req),
    .alu_zero      (alu_zero),
    .mem_ack       (mem_ack),
    .pc            (pc),
    .ir_load       (ir_load),
    .reg_read_en   (reg_read_en),
    .alu_en        (alu_en),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .reg_write_en  (reg_write_en),
    .state_o       (state_o),
    .fault         (fault),
    .retired       (retired)
`ifdef UPOWER_SEQ_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .cycle_count   (cycle_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [73:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] perf_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic logic [73:0] mk(logic [2:0] st, logic [5:0] en, logic flt,
                                     logic [31:0] p, logic [31:0] r);
    return {st, en, flt, p, r};
  endfunction

  always @(negedge clock) begin : monitor
    logic [73:0] e;
    logic [73:0] a;
    logic [63:0] pe;
    string       t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {state_o, ir_load, reg_read_en, alu_en, mem_read_en, mem_write_en,
           reg_write_en, fault, pc, retired};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%0d en=%b flt=%b pc=%h ret=%0d, want st=%0d en=%b flt=%b pc=%h ret=%0d",
                 t, a[73:71], a[70:65], a[64], a[63:32], a[31:0],
                 e[73:71], e[70:65], e[64], e[63:32], e[31:0]);
      end
    end
`ifdef UPOWER_SEQ_PERF_EN
    if (perf_q.size() > 0) begin
      pe = perf_q.pop_front();
      n_cmp++;
      if ({stall_cycles, cycle_count} !== pe) begin
        n_fail++;
        $display("FAIL perf: got stall=%0d cycles=%0d, want stall=%0d cycles=%0d",
                 stall_cycles, cycle_count, pe[63:32], pe[31:0]);
      end
    end
`else
    pe = '0;
    if (perf_q.size() > 0) pe = perf_q.pop_front();
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input string tag, input logic [73:0] e);
    @(posedge clock);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic exp_perf(input logic [31:0] stall, input logic [31:0] cycles);
    perf_q.push_back({stall, cycles});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    reset = 1'b1; run = 1'b0; opcode = 6'd0; li = '0; bd = '0;
    reg_write_req = 1'b0; mem_read_req = 1'b0; mem_write_req = 1'b0;
    branch_req = 1'b0; alu_zero = 1'b0; mem_ack = 1'b0;

    cyc("reset", mk(S_IDLE, EN_0, 0, 32'd0, 32'd0));
    cyc("reset_hold", mk(S_IDLE, EN_0, 0, 32'd0, 32'd0));
    reset = 1'b0;
    cyc("idle_hold", mk(S_IDLE, EN_0, 0, 32'd0, 32'd0));

    // ALU op with writeback
    run = 1'b1; opcode = 6'd31; reg_write_req = 1'b1;
    cyc("a_fetch",  mk(S_FETCH,  EN_F, 0, 32'd0, 32'd0));
    cyc("a_decode", mk(S_DECODE, EN_D, 0, 32'd0, 32'd0));
    cyc("a_exec",   mk(S_EXEC,   EN_E, 0, 32'd0, 32'd0));
    cyc("a_wb",     mk(S_WB,     EN_W, 0, 32'd0, 32'd0));
    cyc("a_retire", mk(S_FETCH,  EN_F, 0, 32'd1, 32'd1));

    // ALU-only op, run dropped during EXEC
    reg_write_req = 1'b0;
    cyc("b_decode", mk(S_DECODE, EN_D, 0, 32'd1, 32'd1));
    cyc("b_exec",   mk(S_EXEC,   EN_E, 0, 32'd1, 32'd1));
    run = 1'b0;
    cyc("b_retire_idle", mk(S_IDLE, EN_0, 0, 32'd2, 32'd2));
    cyc("b_idle_hold",   mk(S_IDLE, EN_0, 0, 32'd2, 32'd2));

    // Load with writeback, ack after three wait cycles
    run = 1'b1; mem_read_req = 1'b1; reg_write_req = 1'b1;
    cyc("c_fetch",  mk(S_FETCH,  EN_F,  0, 32'd2, 32'd2));
    cyc("c_decode", mk(S_DECODE, EN_D,  0, 32'd2, 32'd2));
    cyc("c_exec",   mk(S_EXEC,   EN_E,  0, 32'd2, 32'd2));
    cyc("c_mem1",   mk(S_MEM,    EN_MR, 0, 32'd2, 32'd2));
    for (int i = 0; i < 3; i++) cyc("c_mem_wait", mk(S_MEM, EN_MR, 0, 32'd2, 32'd2));
    mem_ack = 1'b1;
    cyc("c_wb", mk(S_WB, EN_W, 0, 32'd2, 32'd2));
    mem_ack = 1'b0; mem_read_req = 1'b0; reg_write_req = 1'b0;
    cyc("c_retire", mk(S_FETCH, EN_F, 0, 32'd3, 32'd3));
    exp_perf(32'd3, 32'd15);

    // Read and write both requested: write strobe only, immediate ack
    mem_read_req = 1'b1; mem_write_req = 1'b1;
    cyc("d_decode", mk(S_DECODE, EN_D,  0, 32'd3, 32'd3));
    cyc("d_exec",   mk(S_EXEC,   EN_E,  0, 32'd3, 32'd3));
    cyc("d_mem",    mk(S_MEM,    EN_MW, 0, 32'd3, 32'd3));
    mem_ack = 1'b1;
    cyc("d_retire", mk(S_FETCH, EN_F, 0, 32'd4, 32'd4));
    mem_ack = 1'b0; mem_read_req = 1'b0; mem_write_req = 1'b0;

    // Absolute jump to 0x10
    opcode = 6'd18; li = 24'h000010;
    cyc("e_decode", mk(S_DECODE, EN_D, 0, 32'd4, 32'd4));
    cyc("e_exec",   mk(S_EXEC,   EN_E, 0, 32'd4, 32'd4));
    cyc("e_jump",   mk(S_FETCH,  EN_F, 0, 32'h10, 32'd5));

    // Jump to 5
    li = 24'h000005;
    cyc("e2_decode", mk(S_DECODE, EN_D, 0, 32'h10, 32'd5));
    cyc("e2_exec",   mk(S_EXEC,   EN_E, 0, 32'h10, 32'd5));
    cyc("e2_jump",   mk(S_FETCH,  EN_F, 0, 32'd5, 32'd6));

    // Taken branch, bd = -2: 5 + 1 - 2 = 4
    opcode = 6'd16; branch_req = 1'b1; alu_zero = 1'b1; bd = 14'h3FFE;
    cyc("br_t_decode", mk(S_DECODE, EN_D, 0, 32'd5, 32'd6));
    cyc("br_t_exec",   mk(S_EXEC,   EN_E, 0, 32'd5, 32'd6));
    cyc("br_taken",    mk(S_FETCH,  EN_F, 0, 32'd4, 32'd7));

    // Jump with a taken branch condition also present: the jump wins
    opcode = 6'd18; li = 24'h000005;
    cyc("jp_decode", mk(S_DECODE, EN_D, 0, 32'd4, 32'd7));
    cyc("jp_exec",   mk(S_EXEC,   EN_E, 0, 32'd4, 32'd7));
    cyc("jp_prio",   mk(S_FETCH,  EN_F, 0, 32'd5, 32'd8));

    // Branch not taken: 5 + 1 = 6
    opcode = 6'd16; alu_zero = 1'b0;
    cyc("br_n_decode", mk(S_DECODE, EN_D, 0, 32'd5, 32'd8));
    cyc("br_n_exec",   mk(S_EXEC,   EN_E, 0, 32'd5, 32'd8));
    cyc("br_not",      mk(S_FETCH,  EN_F, 0, 32'd6, 32'd9));

    // Reset while waiting in MEM
    opcode = 6'd31; branch_req = 1'b0; mem_read_req = 1'b1; reg_write_req = 1'b1;
    cyc("f_decode", mk(S_DECODE, EN_D,  0, 32'd6, 32'd9));
    cyc("f_exec",   mk(S_EXEC,   EN_E,  0, 32'd6, 32'd9));
    cyc("f_mem1",   mk(S_MEM,    EN_MR, 0, 32'd6, 32'd9));
    cyc("f_mem2",   mk(S_MEM,    EN_MR, 0, 32'd6, 32'd9));
    reset = 1'b1;
    cyc("f_reset_in_mem", mk(S_IDLE, EN_0, 0, 32'd0, 32'd0));
    exp_perf(32'd0, 32'd0);
    reset = 1'b0; mem_read_req = 1'b0; reg_write_req = 1'b0;

    // Move PC off zero, then a store that never gets an ack
    opcode = 6'd18; li = 24'h000020;
    cyc("g_fetch",  mk(S_FETCH,  EN_F, 0, 32'd0, 32'd0));
    cyc("g_decode", mk(S_DECODE, EN_D, 0, 32'd0, 32'd0));
    cyc("g_exec",   mk(S_EXEC,   EN_E, 0, 32'd0, 32'd0));
    cyc("g_jump",   mk(S_FETCH,  EN_F, 0, 32'h20, 32'd1));
    opcode = 6'd31; mem_write_req = 1'b1;
    cyc("g2_decode", mk(S_DECODE, EN_D, 0, 32'h20, 32'd1));
    cyc("g2_exec",   mk(S_EXEC,   EN_E, 0, 32'h20, 32'd1));
    for (int i = 0; i < 15; i++) cyc("g_mem_wait", mk(S_MEM, EN_MW, 0, 32'h20, 32'd1));
    cyc("g_fault", mk(S_FAULT, EN_0, 1, 32'h20, 32'd1));
    exp_perf(32'd15, 32'd21);
    mem_ack = 1'b1;
    cyc("g_fault_hold1", mk(S_FAULT, EN_0, 1, 32'h20, 32'd1));
    cyc("g_fault_hold2", mk(S_FAULT, EN_0, 1, 32'h20, 32'd1));
    mem_ack = 1'b0; reset = 1'b1;
    cyc("g_reset_clears", mk(S_IDLE, EN_0, 0, 32'd0, 32'd0));
    reset = 1'b0; run = 1'b0; mem_write_req = 1'b0;
    cyc("g_idle", mk(S_IDLE, EN_0, 0, 32'd0, 32'd0));

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
